// File: rtl/unidade_de_busca.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | unidade_de_busca                                                           |
// | Instruction fetch unit: OCIOSO/BUSCA/EXECUTA FSM, PC and next-PC selection. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module unidade_de_busca #(
  parameter int                 LARGURA    = 32,
  parameter logic [LARGURA-1:0] PC_INICIAL = '0
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               habilita,
  input  logic               parar,
  output logic               mem_req,
  output logic [LARGURA-1:0] mem_addr,
  input  logic               mem_ack,
  input  logic [LARGURA-1:0] mem_rdata,
  output logic [LARGURA-1:0] instrucao,
  output logic [5:0]         opcode,
  output logic               instr_valid,
  input  logic               jump,
  input  logic               branch,
  input  logic               zero,
  output logic [LARGURA-1:0] pc,
  output logic [1:0]         estado
);

  localparam logic [1:0] c_OCIOSO  = 2'b00;
  localparam logic [1:0] c_BUSCA   = 2'b01;
  localparam logic [1:0] c_EXECUTA = 2'b10;

  localparam logic [5:0] c_OP_BEQ = 6'b000100;
  localparam logic [5:0] c_OP_BNE = 6'b000110;

  logic [1:0]         r_estado;
  logic [LARGURA-1:0] r_pc;
  logic [LARGURA-1:0] r_instrucao;

  logic [LARGURA-1:0] w_pc_mais4;
  logic [LARGURA-1:0] w_imm_ext;
  logic [LARGURA-1:0] w_alvo_desvio;
  logic [LARGURA-1:0] w_alvo_salto;
  logic [LARGURA-1:0] w_prox_pc;
  logic               w_desvio_tomado;

  assign w_pc_mais4    = r_pc + {{(LARGURA-3){1'b0}}, 3'd4};
  assign w_imm_ext     = {{(LARGURA-18){r_instrucao[15]}}, r_instrucao[15:0], 2'b00};
  assign w_alvo_desvio = w_pc_mais4 + w_imm_ext;
  assign w_alvo_salto  = {w_pc_mais4[LARGURA-1:28], r_instrucao[25:0], 2'b00};

  // Only beq/bne are conditional branches; branch on any other opcode falls through.
  always_comb begin
    w_desvio_tomado = 1'b0;
    if (branch) begin
      case (r_instrucao[31:26])
        c_OP_BEQ: w_desvio_tomado = zero;
        c_OP_BNE: w_desvio_tomado = ~zero;
        default:  w_desvio_tomado = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_prox_pc = w_pc_mais4;
    if (jump) begin
      w_prox_pc = w_alvo_salto;
    end else if (w_desvio_tomado) begin
      w_prox_pc = w_alvo_desvio;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado    <= c_OCIOSO;
      r_pc        <= PC_INICIAL;
      r_instrucao <= '0;
    end else begin
      case (r_estado)
        c_OCIOSO: begin
          if (habilita) begin
            r_estado <= c_BUSCA;
          end
        end
        c_BUSCA: begin
          if (mem_ack) begin
            r_instrucao <= mem_rdata;
            r_estado    <= c_EXECUTA;
          end
        end
        c_EXECUTA: begin
          if (!parar) begin
            r_pc     <= w_prox_pc;
            r_estado <= c_BUSCA;
          end
        end
        default: r_estado <= c_OCIOSO;
      endcase
    end
  end

  // Decoded straight from the state register so reset drops them without a clock.
  assign mem_req     = (r_estado == c_BUSCA);
  assign instr_valid = (r_estado == c_EXECUTA);
  assign mem_addr    = r_pc;
  assign pc          = r_pc;
  assign instrucao   = r_instrucao;
  assign opcode      = r_instrucao[31:26];
  assign estado      = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_unidade_de_busca.sv
`default_nettype none
// Testbench for unidade_de_busca: table of fetched instructions with a
// scoreboard of {pc, instruction} pushed at mem_ack and popped at instr_valid.
module tb_unidade_de_busca;

  logic        clock = 1'b0;
  logic        reset_n, habilita, parar, mem_ack, jump, branch, zero;
  logic [31:0] mem_rdata;

  logic        mem_req, instr_valid, mem_req_h, instr_valid_h;
  logic [31:0] mem_addr, instrucao, pc, mem_addr_h, instrucao_h, pc_h;
  logic [5:0]  opcode, opcode_h;
  logic [1:0]  estado, estado_h;

  always #5 clock = ~clock;

  unidade_de_busca dut (
    .clock(clock), .reset_n(reset_n), .habilita(habilita), .parar(parar),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instrucao(instrucao), .opcode(opcode), .instr_valid(instr_valid),
    .jump(jump), .branch(branch), .zero(zero), .pc(pc), .estado(estado)
  );

  // Second instance in the upper address region, used for the jump upper-bits case.
  unidade_de_busca #(.PC_INICIAL(32'h4000_0000)) dut_h (
    .clock(clock), .reset_n(reset_n), .habilita(habilita), .parar(parar),
    .mem_req(mem_req_h), .mem_addr(mem_addr_h), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instrucao(instrucao_h), .opcode(opcode_h), .instr_valid(instr_valid_h),
    .jump(jump), .branch(branch), .zero(zero), .pc(pc_h), .estado(estado_h)
  );

  typedef struct {
    logic [31:0] instr;
    logic        jmp;
    logic        br;
    logic        z;
    int          ack_wait;
    int          stall;
    logic [31:0] pc_exp;
    logic [31:0] next_exp;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;

  vec_t vecs[15];
  sb_t  sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    checks++;
    if (atual !== esperado) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", nome, atual, esperado);
    end
  endtask

  task automatic run_vec(input vec_t v);
    sb_t e;
    for (int k = 0; k < v.ack_wait; k++) begin
      chk("busca_wait_req", {31'd0, mem_req}, 32'd1);
      chk("busca_wait_addr", mem_addr, v.pc_exp);
      mem_ack = 1'b0;
      @(negedge clock);
    end
    chk("busca_req", {31'd0, mem_req}, 32'd1);
    chk("busca_addr", mem_addr, v.pc_exp);
    chk("busca_estado", {30'd0, estado}, 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = v.instr;
    sb_q.push_back('{v.pc_exp, v.instr});
    @(negedge clock);
    // Ack with stale data while executing must be ignored.
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    chk("sb_depth", sb_q.size(), 32'd1);
    e = sb_q.pop_front();
    chk("exec_valid", {31'd0, instr_valid}, 32'd1);
    chk("exec_pc", pc, e.pc);
    chk("exec_instrucao", instrucao, e.instr);
    chk("exec_opcode", {26'd0, opcode}, {26'd0, e.instr[31:26]});
    chk("exec_req", {31'd0, mem_req}, 32'd0);
    for (int s = 0; s < v.stall; s++) begin
      parar  = 1'b1;
      jump   = ~v.jmp;
      branch = 1'b1;
      zero   = ~v.z;
      @(negedge clock);
      chk("stall_pc", pc, e.pc);
      chk("stall_instrucao", instrucao, e.instr);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_req", {31'd0, mem_req}, 32'd0);
    end
    parar  = 1'b0;
    jump   = v.jmp;
    branch = v.br;
    zero   = v.z;
    @(negedge clock);
    jump    = 1'b0;
    branch  = 1'b0;
    zero    = 1'b0;
    mem_ack = 1'b0;
    chk("next_pc", mem_addr, v.next_exp);
    chk("next_estado", {30'd0, estado}, 32'd1);
    chk("next_valid", {31'd0, instr_valid}, 32'd0);
    chk("opcode_idle", {26'd0, opcode}, {26'd0, e.instr[31:26]});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //               instr         j     b     z     ack st  pc            next
    vecs[0]  = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0000_0000, 32'h0000_0004};
    vecs[1]  = '{32'h1000_0100, 1'b1, 1'b1, 1'b1, 0, 0, 32'h0000_0004, 32'h0000_0400};
    vecs[2]  = '{32'h0800_0004, 1'b1, 1'b0, 1'b0, 5, 0, 32'h0000_0400, 32'h0000_0010};
    vecs[3]  = '{32'h1000_FFFE, 1'b0, 1'b1, 1'b0, 0, 3, 32'h0000_0010, 32'h0000_0014};
    vecs[4]  = '{32'h0800_0004, 1'b1, 1'b0, 1'b0, 1, 0, 32'h0000_0014, 32'h0000_0010};
    vecs[5]  = '{32'h1000_FFFE, 1'b0, 1'b1, 1'b1, 0, 0, 32'h0000_0010, 32'h0000_000C};
    vecs[6]  = '{32'h0800_0008, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0000_000C, 32'h0000_0020};
    vecs[7]  = '{32'h1800_0003, 1'b0, 1'b1, 1'b1, 0, 1, 32'h0000_0020, 32'h0000_0024};
    vecs[8]  = '{32'h0800_0008, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0000_0024, 32'h0000_0020};
    vecs[9]  = '{32'h1800_0003, 1'b0, 1'b1, 1'b0, 2, 0, 32'h0000_0020, 32'h0000_0030};
    vecs[10] = '{32'h1000_0005, 1'b0, 1'b0, 1'b1, 0, 0, 32'h0000_0030, 32'h0000_0034};
    vecs[11] = '{32'h8C00_0010, 1'b0, 1'b1, 1'b1, 0, 0, 32'h0000_0034, 32'h0000_0038};
    vecs[12] = '{32'h1000_FFF0, 1'b0, 1'b1, 1'b1, 0, 0, 32'h0000_0038, 32'hFFFF_FFFC};
    vecs[13] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 0, 0, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[14] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0000_0000, 32'h0000_0004};

    reset_n   = 1'b1;
    habilita  = 1'b0;
    parar     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    jump      = 1'b0;
    branch    = 1'b0;
    zero      = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_estado", {30'd0, estado}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instrucao", instrucao, 32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_pc_h", pc_h, 32'h4000_0000);

    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("ocioso_hold", {30'd0, estado}, 32'd0);
    chk("ocioso_ack_ignored", instrucao, 32'h0);
    chk("ocioso_req", {31'd0, mem_req}, 32'd0);
    habilita = 1'b1;
    @(negedge clock);
    chk("start_estado", {30'd0, estado}, 32'd1);
    habilita = 1'b0;
    mem_ack  = 1'b0;

    for (int i = 0; i < 15; i++) begin
      run_vec(vecs[i]);
      if (i == 0) chk("hi_seq_pc", mem_addr_h, 32'h4000_0004);
      if (i == 1) chk("hi_jump_pc", mem_addr_h, 32'h4000_0400);
    end

    // Reset in the middle of a fetch, then a late ack.
    chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_estado", {30'd0, estado}, 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    habilita  = 1'b1;
    @(negedge clock);
    chk("rst_held_instrucao", instrucao, 32'h0);
    reset_n = 1'b1;
    #1;
    chk("rst_release_no_step", {30'd0, estado}, 32'd0);
    @(negedge clock);
    chk("post_rst_estado", {30'd0, estado}, 32'd1);
    chk("post_rst_ack_ignored", instrucao, 32'h0);
    chk("post_rst_addr", mem_addr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/unidade_de_busca.md
UNIDADE_DE_BUSCA -- requirements
Module: unidade_de_busca

Interface
REQ-001 Parameter: PC_INICIAL, default 32'h00000000, address fetched first after reset; low two bits SHALL be zero.
REQ-002 Parameter: LARGURA, default 32, width of PC, instruction and memory data.
REQ-003 Port: clock  in  1  single system clock; all state updates on rising edge.
REQ-004 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-005 Port: habilita  in  1  start/continue fetching; sampled only in state OCIOSO.
REQ-006 Port: parar  in  1  datapath stall; holds the current instruction in EXECUTA.
REQ-007 Port: mem_req  out  1  instruction-memory read request.
REQ-008 Port: mem_addr  out  32  instruction-memory word address (byte address, aligned).
REQ-009 Port: mem_ack  in  1  memory read data valid on mem_rdata this cycle.
REQ-010 Port: mem_rdata  in  32  instruction word returned by memory.
REQ-011 Port: instrucao  out  32  registered instruction word.
REQ-012 Port: opcode  out  6  instrucao[31:26], driven to the control unit.
REQ-013 Port: instr_valid  out  1  instrucao is valid and executing this cycle.
REQ-014 Port: jump, branch  in  1 each  control-unit outputs decoded from opcode.
REQ-015 Port: zero  in  1  ALU zero flag for the executing instruction.
REQ-016 Port: pc  out  32  address of the instruction in instrucao.
REQ-017 Port: estado  out  2  current FSM state (debug).

Function
REQ-018 FSM states SHALL be OCIOSO=2'b00, BUSCA=2'b01, EXECUTA=2'b10; 2'b11 SHALL be unreachable and, if entered, return to OCIOSO next cycle.
REQ-019 OCIOSO: mem_req=0, instr_valid=0; habilita=1 -> BUSCA next cycle, else stay.
REQ-020 BUSCA: mem_req=1 and mem_addr=pc every cycle; mem_ack=0 -> stay; mem_ack=1 -> capture mem_rdata into instrucao, go EXECUTA next cycle.
REQ-021 mem_ack SHALL be ignored in OCIOSO and EXECUTA; mem_req SHALL be 0 outside BUSCA.
REQ-022 EXECUTA: instr_valid=1, mem_req=0; parar=1 -> stay with pc and instrucao unchanged; parar=0 -> update pc per REQ-023..026 and go BUSCA next cycle.
REQ-023 Next PC default SHALL be pc+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-024 jump=1 SHALL take next PC = {pc_plus4[31:28], instrucao[25:0], 2'b00}; jump has priority over branch.
REQ-025 branch=1 with opcode 6'b000100 (beq) and zero=1, or opcode 6'b000110 (bne) and zero=0, SHALL take next PC = pc+4 + (sign-extended instrucao[15:0] << 2), modulo 2^32; otherwise pc+4.
REQ-026 branch=1 with any other opcode SHALL be treated as not taken.
REQ-027 Minimum fetch-to-execute latency: 1 cycle from BUSCA entry (ack in first BUSCA cycle) to instr_valid=1; one instruction per 2 cycles at best.
REQ-028 jump, branch, zero SHALL be sampled only in the EXECUTA cycle with parar=0.
REQ-029 habilita=0 SHALL not interrupt BUSCA or EXECUTA; after EXECUTA the FSM always goes to BUSCA.
REQ-030 opcode SHALL always equal instrucao[31:26], including when instr_valid=0.

Reset
REQ-031 reset_n=0 SHALL immediately, without a clock, force: estado=OCIOSO, pc=PC_INICIAL, instrucao=0, instr_valid=0, mem_req=0, mem_addr=PC_INICIAL.
REQ-032 Reset asserted mid-BUSCA SHALL drop mem_req the same instant; a later mem_ack SHALL be ignored.
REQ-033 After reset_n rises, the first transition SHALL occur no earlier than the next rising clock edge.

Verification
REQ-034 Reset, habilita=1, mem_ack=1 immediately, mem_rdata=0x00000000 (R-type) -> mem_addr=0x0, instr_valid after 1 cycle, next mem_addr=0x4.
REQ-035 pc=0x10, instrucao=0x1000FFFE (beq, imm=-2), branch=1, zero=1 -> next pc=0x0C; zero=0 -> next pc=0x14.
REQ-036 pc=0x20, opcode 6'b000110 (bne) imm=3, branch=1, zero=0 -> next pc=0x30; zero=1 -> 0x24.
REQ-037 pc=0x40000000, jump=1, instrucao[25:0]=0x0000100, branch=1 also -> next pc=0x40000400 (jump wins).
REQ-038 mem_ack held low 5 cycles in BUSCA -> mem_req=1, mem_addr stable for all 5; parar=1 for 3 cycles in EXECUTA -> pc, instrucao, instr_valid=1 unchanged.
REQ-039 pc=0xFFFFFFFC, no jump/branch -> next pc=0x00000000; reset_n pulsed low mid-BUSCA -> mem_req=0 asynchronously, pc=PC_INICIAL.
